// File: rtl/program_loader_if.sv
// Host byte link into the program loader: one byte per cycle on valid && ready.
interface program_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Boot-time loader: takes a LEN/data/CSUM frame from the host, writes the data into RAM
// and keeps the CPU in reset until a frame with a matching checksum has been stored.
module program_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    program_loader_if.slave   host,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              cpu_reset,
    output logic              loading,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    localparam int                IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;
    localparam logic [31:0]       MEM_DEPTH = 32'(2 ** ADDR_W);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    state_t            state_reg;
    logic              in_ready_reg;
    logic              ram_we_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [7:0]        ram_data_reg;
    logic              cpu_reset_reg;
    logic              loading_reg;
    logic              done_reg;
    logic              error_reg;
    logic [1:0]        err_code_reg;
    logic [8:0]        len_reg;
    logic [8:0]        idx_reg;
    logic [7:0]        sum_reg;
    logic [IDLE_W-1:0] idle_reg;

    logic       accept;
    logic       timeout_hit;
    logic       len_overflow;
    logic       last_data;
    logic [8:0] len_next;

    assign accept       = host.in_valid && in_ready_reg;
    assign timeout_hit  = (TIMEOUT != 0) && (idle_reg == IDLE_LAST);
    assign len_next     = (host.in_data == 8'd0) ? 9'd256 : {1'b0, host.in_data};
    // Whole frame must fit above BASE_ADDR, so the write index can never wrap.
    assign len_overflow = (32'(BASE_ADDR) + 32'(len_next)) > MEM_DEPTH;
    assign last_data    = (idx_reg + 9'd1) == len_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            in_ready_reg  <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_data_reg  <= 8'd0;
            cpu_reset_reg <= 1'b1;
            loading_reg   <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            err_code_reg  <= 2'd0;
            len_reg       <= 9'd0;
            idx_reg       <= 9'd0;
            sum_reg       <= 8'd0;
            idle_reg      <= '0;
        end else begin
            ram_we_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_reg     <= S_LEN;
                        in_ready_reg  <= 1'b1;
                        loading_reg   <= 1'b1;
                        cpu_reset_reg <= 1'b1;
                        done_reg      <= 1'b0;
                        error_reg     <= 1'b0;
                        err_code_reg  <= 2'd0;
                        idle_reg      <= '0;
                    end
                end
                S_LEN, S_DATA, S_CSUM: begin
                    if (accept) begin
                        idle_reg <= '0;
                        if (state_reg == S_LEN) begin
                            if (len_overflow) begin
                                state_reg    <= S_ERR;
                                in_ready_reg <= 1'b0;
                                loading_reg  <= 1'b0;
                                error_reg    <= 1'b1;
                                err_code_reg <= 2'd3;
                            end else begin
                                state_reg <= S_DATA;
                                len_reg   <= len_next;
                                idx_reg   <= 9'd0;
                                sum_reg   <= 8'd0;
                            end
                        end else if (state_reg == S_DATA) begin
                            ram_we_reg   <= 1'b1;
                            ram_addr_reg <= BASE + ADDR_W'(idx_reg);
                            ram_data_reg <= host.in_data;
                            sum_reg      <= sum_reg + host.in_data;
                            idx_reg      <= idx_reg + 9'd1;
                            if (last_data) state_reg <= S_CSUM;
                        end else begin
                            in_ready_reg <= 1'b0;
                            loading_reg  <= 1'b0;
                            if (host.in_data == sum_reg) begin
                                state_reg     <= S_DONE;
                                cpu_reset_reg <= 1'b0;
                                done_reg      <= 1'b1;
                            end else begin
                                state_reg    <= S_ERR;
                                error_reg    <= 1'b1;
                                err_code_reg <= 2'd1;
                            end
                        end
                    end else if (timeout_hit) begin
                        state_reg    <= S_ERR;
                        in_ready_reg <= 1'b0;
                        loading_reg  <= 1'b0;
                        error_reg    <= 1'b1;
                        err_code_reg <= 2'd2;
                    end else begin
                        idle_reg <= idle_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg    <= S_IDLE;
                    in_ready_reg <= 1'b0;
                    loading_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign host.in_ready = in_ready_reg;
    assign ram_we        = ram_we_reg;
    assign ram_addr      = ram_addr_reg;
    assign ram_data      = ram_data_reg;
    assign cpu_reset     = cpu_reset_reg;
    assign loading       = loading_reg;
    assign done          = done_reg;
    assign error         = error_reg;
    assign err_code      = err_code_reg;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal, checksum, timeout, length-256/overflow,
// mid-frame reset and gapped-stream scenarios, one line per checked transaction.
module tb_program_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start0, start1;
    program_loader_if h0();
    program_loader_if h1();

    logic       ram_we0, cpu_reset0, loading0, done0, error0;
    logic [7:0] ram_addr0, ram_data0;
    logic [1:0] err_code0;
    logic       ram_we1, cpu_reset1, loading1, done1, error1;
    logic [7:0] ram_addr1, ram_data1;
    logic [1:0] err_code1;

    program_loader #(.ADDR_W(8), .BASE_ADDR(0), .TIMEOUT(16)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .host(h0),
        .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_data(ram_data0),
        .cpu_reset(cpu_reset0), .loading(loading0), .done(done0),
        .error(error0), .err_code(err_code0)
    );

    program_loader #(.ADDR_W(8), .BASE_ADDR(1), .TIMEOUT(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .host(h1),
        .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_data(ram_data1),
        .cpu_reset(cpu_reset1), .loading(loading1), .done(done1),
        .error(error1), .err_code(err_code1)
    );

    // flags = {in_ready, ram_we, cpu_reset, loading, done, error}
    logic [5:0] flags0, flags1;
    assign flags0 = {h0.in_ready, ram_we0, cpu_reset0, loading0, done0, error0};
    assign flags1 = {h1.in_ready, ram_we1, cpu_reset1, loading1, done1, error1};

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int we1_cnt = 0;
    int first_acc, last_acc;
    logic [7:0]  pat [256];
    logic [47:0] got_q[$];   // {addr, data, cycle}
    logic [47:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ram_we0) got_q.push_back({ram_addr0, ram_data0, 32'(cyc)});
    always @(negedge clk) if (ram_we1) we1_cnt <= we1_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic pulse_start0();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_data, input logic [7:0] addr);
        int w;
        @(negedge clk);
        h0.in_valid = 1'b1;
        h0.in_data  = b;
        w = 0;
        while (!h0.in_ready && w < 50) begin @(negedge clk); w++; end
        if (!h0.in_ready) begin
            tests++; failed++;
            $display("FAIL accept_wait: byte %h not accepted, in_ready=%b required 1", b, h0.in_ready);
            h0.in_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        if (is_data) exp_q.push_back({addr, b, 32'(cyc + 1)});
        @(posedge clk); #1;
        h0.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int n_send, input logic [7:0] len_byte, input logic [7:0] csum,
                              input bit with_csum, input int max_gap, input int start_at);
        send_byte(len_byte, 1'b0, 8'h00);
        first_acc = last_acc;
        for (int i = 0; i < n_send; i++) begin
            if (max_gap > 0) repeat (int'($urandom_range(0, max_gap))) @(negedge clk);
            if (i == start_at) pulse_start0();
            send_byte(pat[i], 1'b1, 8'(i));
        end
        if (with_csum) begin
            if (max_gap > 0) repeat (int'($urandom_range(0, max_gap))) @(negedge clk);
            send_byte(csum, 1'b0, 8'h00);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
        h0.in_valid = 1'b0; h0.in_data = 8'h00;
        h1.in_valid = 1'b0; h1.in_data = 8'h00;
        repeat (3) @(negedge clk);
        tests++;
        if (flags0 !== 6'b001000) begin failed++; $display("FAIL reset_flags0: got %b expected 001000", flags0); end
        tests++;
        if ({ram_addr0, ram_data0, err_code0} !== 18'h0) begin
            failed++; $display("FAIL reset_bus0: got addr %h data %h code %0d expected 0 0 0", ram_addr0, ram_data0, err_code0);
        end
        tests++;
        if (flags1 !== 6'b001000) begin failed++; $display("FAIL reset_flags1: got %b expected 001000", flags1); end
        reset = 1'b1;
        h0.in_valid = 1'b1; h0.in_data = 8'h02;
        repeat (4) @(negedge clk);
        h0.in_valid = 1'b0;
        tests++;
        if (flags0 !== 6'b001000 || got_q.size() != 0) begin
            failed++; $display("FAIL idle_ignore: got flags %b writes %0d expected 001000 0", flags0, got_q.size());
        end
        $display("[TB] reset: done");
    endtask

    task automatic test_normal();
        int bad;
        pat[0] = 8'hAA; pat[1] = 8'hBB; pat[2] = 8'hCC;
        got_q.delete(); exp_q.delete();
        pulse_start0();
        tests++;
        if (flags0 !== 6'b101100) begin failed++; $display("FAIL t1_start: got %b expected 101100", flags0); end
        send_frame(3, 8'h03, 8'h31, 1'b0, 0, -1);
        tests++;
        if (flags0 !== 6'b111100) begin failed++; $display("FAIL t1_pre_csum: got %b expected 111100", flags0); end
        send_byte(8'h31, 1'b0, 8'h00);
        tests++;
        if (flags0 !== 6'b000010) begin failed++; $display("FAIL t1_done: got %b expected 000010", flags0); end
        repeat (2) @(negedge clk);
        tests++; bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        if (bad < 0 && got_q.size() != exp_q.size()) bad = exp_q.size();
        if (bad >= 0) begin
            failed++; $display("FAIL t1_writes: entry %0d got %0d writes, expected %h", bad, got_q.size(), exp_q[0]);
        end
        $display("[TB] T1 normal load: %0d writes", got_q.size());
    endtask

    task automatic test_bad_csum();
        int bad;
        got_q.delete(); exp_q.delete();
        pulse_start0();
        tests++;
        if (flags0 !== 6'b101100) begin failed++; $display("FAIL t2_restart: got %b expected 101100", flags0); end
        send_frame(3, 8'h03, 8'h32, 1'b1, 0, -1);
        tests++;
        if ({flags0, err_code0} !== 8'b001001_01) begin
            failed++; $display("FAIL t2_error: got %b code %0d expected 001001 code 1", flags0, err_code0);
        end
        repeat (2) @(negedge clk);
        tests++; bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        if (bad < 0 && got_q.size() != exp_q.size()) bad = exp_q.size();
        if (bad >= 0) begin failed++; $display("FAIL t2_writes: entry %0d, got %0d writes expected 3", bad, got_q.size()); end
        pulse_start0();
        tests++;
        if ({flags0, err_code0} !== 8'b101100_00) begin
            failed++; $display("FAIL t2_clear: got %b code %0d expected 101100 code 0", flags0, err_code0);
        end
        send_frame(3, 8'h03, 8'h31, 1'b1, 0, -1);
        tests++;
        if (flags0 !== 6'b000010) begin failed++; $display("FAIL t2_reload: got %b expected 000010", flags0); end
        $display("[TB] T2 bad checksum then reload");
    endtask

    task automatic test_timeout();
        int bad;
        pat[0] = 8'h11; pat[1] = 8'h22;
        pulse_start0();
        got_q.delete(); exp_q.delete();
        send_frame(2, 8'h04, 8'h00, 1'b0, 0, -1);
        repeat (15) @(posedge clk);
        #1;
        tests++;
        if (flags0 !== 6'b101100) begin failed++; $display("FAIL t3_early: got %b expected 101100 at 15 idle cycles", flags0); end
        @(posedge clk); #1;
        tests++;
        if ({flags0, err_code0} !== 8'b001001_10) begin
            failed++; $display("FAIL t3_timeout: got %b code %0d expected 001001 code 2", flags0, err_code0);
        end
        repeat (4) @(negedge clk);
        tests++; bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        if (bad < 0 && got_q.size() != exp_q.size()) bad = exp_q.size();
        if (bad >= 0) begin failed++; $display("FAIL t3_writes: entry %0d, got %0d writes expected 2", bad, got_q.size()); end
        $display("[TB] T3 timeout");
    endtask

    task automatic test_len0();
        int bad;
        for (int i = 0; i < 256; i++) pat[i] = 8'(i);
        pulse_start0();
        got_q.delete(); exp_q.delete();
        send_frame(256, 8'h00, 8'h80, 1'b1, 0, -1);
        tests++;
        if (flags0 !== 6'b000010) begin failed++; $display("FAIL t4_done: got %b expected 000010", flags0); end
        tests++;
        if (last_acc - first_acc != 257) begin
            failed++; $display("FAIL t4_back_to_back: got %0d cycles expected 257", last_acc - first_acc);
        end
        repeat (2) @(negedge clk);
        tests++; bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        if (bad < 0 && got_q.size() != exp_q.size()) bad = exp_q.size();
        if (bad >= 0) begin failed++; $display("FAIL t4_writes: entry %0d, got %0d writes expected 256", bad, got_q.size()); end
        // Overflow on the BASE_ADDR=1 instance, whose timeout is disabled.
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (20) @(negedge clk);
        tests++;
        if (flags1 !== 6'b101100) begin failed++; $display("FAIL t4_no_timeout: got %b expected 101100", flags1); end
        h1.in_valid = 1'b1; h1.in_data = 8'h00;
        @(posedge clk); #1;
        h1.in_valid = 1'b0;
        tests++;
        if ({flags1, err_code1} !== 8'b001001_11) begin
            failed++; $display("FAIL t4_overflow: got %b code %0d expected 001001 code 3", flags1, err_code1);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (we1_cnt != 0) begin failed++; $display("FAIL t4_overflow_we: got %0d writes expected 0", we1_cnt); end
        $display("[TB] T4 length 256 and overflow");
    endtask

    task automatic test_reset_midframe();
        int bad;
        pat[0] = 8'h01; pat[1] = 8'h02;
        pulse_start0();
        got_q.delete(); exp_q.delete();
        send_frame(2, 8'h05, 8'h00, 1'b0, 0, -1);
        @(negedge clk); #2;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (flags0 !== 6'b001000 || {ram_addr0, ram_data0, err_code0} !== 18'h0) begin
            failed++; $display("FAIL t5_reset: got %b addr %h data %h expected 001000 00 00", flags0, ram_addr0, ram_data0);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (flags0 !== 6'b001000) begin failed++; $display("FAIL t5_idle: got %b expected 001000", flags0); end
        pat[0] = 8'h10; pat[1] = 8'h20; pat[2] = 8'h30; pat[3] = 8'h40; pat[4] = 8'h50;
        pulse_start0();
        send_frame(5, 8'h05, 8'hF0, 1'b1, 0, -1);
        tests++;
        if (flags0 !== 6'b000010) begin failed++; $display("FAIL t5_done: got %b expected 000010", flags0); end
        repeat (2) @(negedge clk);
        tests++; bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        if (bad < 0 && got_q.size() != exp_q.size()) bad = exp_q.size();
        if (bad >= 0) begin failed++; $display("FAIL t5_writes: entry %0d, got %0d writes expected 7", bad, got_q.size()); end
        $display("[TB] T5 mid-frame reset then reload");
    endtask

    task automatic test_gaps();
        int bad;
        pat[0] = 8'h5A; pat[1] = 8'hA5; pat[2] = 8'h0F; pat[3] = 8'hF0;
        pulse_start0();
        got_q.delete(); exp_q.delete();
        send_frame(4, 8'h04, 8'hFE, 1'b1, 5, 2);
        tests++;
        if (flags0 !== 6'b000010) begin failed++; $display("FAIL t6_done: got %b expected 000010", flags0); end
        repeat (2) @(negedge clk);
        tests++; bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        if (bad < 0 && got_q.size() != exp_q.size()) bad = exp_q.size();
        if (bad >= 0) begin failed++; $display("FAIL t6_writes: entry %0d, got %0d writes expected 4", bad, got_q.size()); end
        $display("[TB] T6 gapped stream with ignored start");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_csum();
        test_timeout();
        test_len0();
        test_reset_midframe();
        test_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
